// File: rtl/count_seq_ctrl_if.sv
// Board-side signal bundle for the counter sequencer: raw switches, clear request and LED outputs.
interface count_seq_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             x;
    logic             run;
    logic             clr;
    logic [CNT_W-1:0] cnt;
    logic             z;
    logic             zl;
    logic [1:0]       state;

    modport master (output x, run, clr, input cnt, z, zl, state);
    modport slave  (input x, run, clr, output cnt, z, zl, state);
endinterface

// File: rtl/count_seq_ctrl.sv
// Modulo counter sequencer: switch synchronizers, optional step debounce (DEBOUNCE_EN),
// manual-step / free-run FSM with clear, wrap pulse and terminal-count outputs.
module count_seq_ctrl #(
    parameter int MOD       = 4,
    parameter int CNT_W     = 2,
    parameter int DB_CYCLES = 16,
    parameter int TICK_DIV  = 8
) (
    input  logic            cp,
    input  logic            rd,
    count_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        CLR  = 2'b10
    } state_t;

    localparam int               DIV_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    logic x_s1_q, xs_q, run_s1_q, runs_q, xf_prev_q;
    logic xf, step;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             z_q, z_d, zl_q, zl_d;
    logic             inc;

    always_ff @(posedge cp or posedge rd) begin
        if (rd) begin
            x_s1_q    <= 1'b0;
            xs_q      <= 1'b0;
            run_s1_q  <= 1'b0;
            runs_q    <= 1'b0;
            xf_prev_q <= 1'b0;
        end else begin
            x_s1_q    <= bus.x;
            xs_q      <= x_s1_q;
            run_s1_q  <= bus.run;
            runs_q    <= run_s1_q;
            xf_prev_q <= xf;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int              DB_W   = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    logic            xf_q;
    logic [DB_W-1:0] db_cnt_q;

    // xf follows xs only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge cp or posedge rd) begin
        if (rd) begin
            xf_q     <= 1'b0;
            db_cnt_q <= '0;
        end else if (xs_q == xf_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_MAX) begin
            xf_q     <= xs_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    assign xf = xf_q;
`else
    assign xf = xs_q;
`endif

    // A step is the release (falling edge) of the filtered switch level.
    assign step = xf_prev_q & ~xf;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    state_d = CLR;
                    cnt_d   = '0;
                    div_d   = '0;
                end else begin
                    inc = step;
                    if (runs_q) state_d = RUN;
                end
            end
            RUN: begin
                if (bus.clr) begin
                    state_d = CLR;
                    cnt_d   = '0;
                    div_d   = '0;
                end else if (!runs_q) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    inc   = (div_q == DIV_MAX);
                    div_d = inc ? '0 : div_q + 1'b1;
                end
            end
            CLR: begin
                cnt_d = '0;
                div_d = '0;
                if (!bus.clr) state_d = runs_q ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (inc) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        z_d  = inc && (cnt_q == CNT_MAX);
        zl_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge cp or posedge rd) begin
        if (rd) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            z_q     <= 1'b0;
            zl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            z_q     <= z_d;
            zl_q    <= zl_d;
        end
    end

    assign bus.cnt   = cnt_q;
    assign bus.z     = z_q;
    assign bus.zl    = zl_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: reset, manual steps, debounce glitch (DEBOUNCE_EN), RUN, clear priority.
`timescale 1ns/1ps
module tb_count_seq_ctrl;
    localparam int MOD       = 4;
    localparam int CNT_W     = 2;
    localparam int DB_CYCLES = 16;
    localparam int TICK_DIV  = 8;
`ifdef DEBOUNCE_EN
    localparam int STEP_LAT  = 3 + DB_CYCLES;
`else
    localparam int STEP_LAT  = 3;
`endif
    localparam int SETTLE    = STEP_LAT + 3;

    logic cp = 1'b0;
    logic rd = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;

    count_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    count_seq_ctrl #(
        .MOD(MOD), .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES), .TICK_DIV(TICK_DIV)
    ) dut (
        .cp(cp),
        .rd(rd),
        .bus(bus)
    );

    always #5 cp = ~cp;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [CNT_W-1:0] c, input logic zz,
                             input logic zzl, input logic [1:0] st);
        check({tag, " cnt"}, 8'(bus.cnt), 8'(c));
        check({tag, " z"}, 8'(bus.z), 8'(zz));
        check({tag, " zl"}, 8'(bus.zl), 8'(zzl));
        check({tag, " state"}, 8'(bus.state), 8'(st));
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge cp);
    endtask

    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(MOD - 1)) ? '0 : c + 1'b1;
    endfunction

    task automatic manual_step(input string tag);
        logic [CNT_W-1:0] prev, exp;
        prev = model_cnt;
        exp_q.push_back(next_cnt(prev));
        bus.x = 1'b0;
        edges(STEP_LAT - 1);
        check({tag, " early"}, 8'(bus.cnt), 8'(prev));
        edges(1);
        exp = exp_q.pop_front();
        check({tag, " cnt"}, 8'(bus.cnt), 8'(exp));
        check({tag, " z"}, 8'(bus.z), 8'(prev == CNT_W'(MOD - 1)));
        check({tag, " zl"}, 8'(bus.zl), 8'(exp == CNT_W'(MOD - 1)));
        edges(1);
        check({tag, " z low"}, 8'(bus.z), 8'd0);
        model_cnt = exp;
        bus.x = 1'b1;
        edges(SETTLE);
    endtask

    task automatic run_interval(input string tag);
        logic [CNT_W-1:0] prev, exp;
        prev = model_cnt;
        exp_q.push_back(next_cnt(prev));
        edges(TICK_DIV - 1);
        check({tag, " early"}, 8'(bus.cnt), 8'(prev));
        edges(1);
        exp = exp_q.pop_front();
        check({tag, " cnt"}, 8'(bus.cnt), 8'(exp));
        check({tag, " z"}, 8'(bus.z), 8'(prev == CNT_W'(MOD - 1)));
        check({tag, " zl"}, 8'(bus.zl), 8'(exp == CNT_W'(MOD - 1)));
        model_cnt = exp;
    endtask

    initial begin
        int n;
        bus.x   = 1'b0;
        bus.run = 1'b0;
        bus.clr = 1'b0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 12; i++) begin
            @(negedge cp);
            bus.x   = 1'($urandom_range(0, 1));
            bus.run = 1'($urandom_range(0, 1));
            bus.clr = 1'($urandom_range(0, 1));
            check_out("reset hold", '0, 1'b0, 1'b0, 2'b00);
        end
        bus.x   = 1'b1;
        bus.run = 1'b0;
        bus.clr = 1'b0;
        @(negedge cp);
        rd = 1'b0;
        edges(SETTLE);
        check_out("after reset", '0, 1'b0, 1'b0, 2'b00);

        // Manual steps: 1,2,3,0,1.
        for (int i = 0; i < 5; i++) manual_step($sformatf("step%0d", i));

`ifdef DEBOUNCE_EN
        bus.x = 1'b0;
        edges(10);
        bus.x = 1'b1;
        edges(SETTLE + 10);
        check("glitch cnt", 8'(bus.cnt), 8'(model_cnt));
`endif

        // Async reset mid-count at cnt=2, between clock edges.
        manual_step("step5");
        check("pre reset cnt", 8'(bus.cnt), 8'd2);
        #2 rd = 1'b1;
        #1 check_out("async reset", '0, 1'b0, 1'b0, 2'b00);
        model_cnt = '0;
        @(negedge cp);
        rd = 1'b0;
        edges(SETTLE);
        check_out("post reset idle", '0, 1'b0, 1'b0, 2'b00);

        // RUN mode entry and free-running increments, with x steps ignored.
        bus.run = 1'b1;
        n = 0;
        while (bus.state != 2'b01 && n < 10) begin
            edges(1);
            n++;
        end
        check("run entry edges", 8'(n), 8'd3);
        bus.x = 1'b0;
        for (int i = 0; i < 4; i++) run_interval($sformatf("run%0d", i));
        bus.x = 1'b1;
        run_interval("run4");

        // Clear with the divider at TICK_DIV-1: the tick must be dropped.
        edges(TICK_DIV - 1);
        check("pre clr cnt", 8'(bus.cnt), 8'(model_cnt));
        bus.clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edges(1);
            check_out($sformatf("clr hold%0d", i), '0, 1'b0, 1'b0, 2'b10);
        end
        bus.clr = 1'b0;
        edges(1);
        check_out("clr exit", '0, 1'b0, 1'b0, 2'b01);
        model_cnt = '0;
        run_interval("post clr");

        // Drop run: back to IDLE with count held.
        bus.run = 1'b0;
        edges(2);
        check("run drop wait", 8'(bus.state), 8'd1);
        edges(1);
        check("run drop state", 8'(bus.state), 8'd0);
        check("run drop cnt", 8'(bus.cnt), 8'(model_cnt));
        edges(10);
        check("idle hold cnt", 8'(bus.cnt), 8'(model_cnt));

        // Step and clear land on the same edge: clear wins.
        bus.x = 1'b0;
        edges(STEP_LAT - 1);
        bus.clr = 1'b1;
        edges(1);
        check_out("collide", '0, 1'b0, 1'b0, 2'b10);
        bus.clr = 1'b0;
        edges(1);
        check("collide exit state", 8'(bus.state), 8'd0);
        bus.x = 1'b1;
        edges(SETTLE);
        check_out("collide settle", '0, 1'b0, 1'b0, 2'b00);
        check("queue empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
